// File: rtl/dpram_param.sv
// Parameterised simple dual-port RAM: one write port, one read port, one clock.
// Byte enables, collision policy, post-reset clear, read-valid tagging, range errors.
module dpram_param #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned DEPTH          = 16,
   parameter int unsigned ADDR_WIDTH     = 4,
   parameter int unsigned RD_LATENCY     = 1,
   parameter int unsigned COLLISION_MODE = 0,
   parameter int unsigned INIT_ON_RESET  = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    we,
   input  logic [ADDR_WIDTH-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic [DATA_WIDTH/8-1:0] wbe,
   input  logic                    re,
   input  logic [ADDR_WIDTH-1:0]   raddr,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    rvalid,
   output logic                    rd_err,
   output logic                    wr_err,
   output logic                    init_done
);
   localparam int unsigned NB                = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("dpram_param: DATA_WIDTH must be a multiple of 8");
   end
   if ((2 ** ADDR_WIDTH) < DEPTH) begin : g_bad_addr
      $error("dpram_param: ADDR_WIDTH too small for DEPTH");
   end
   if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
      $error("dpram_param: RD_LATENCY must be 1 or 2");
   end

   typedef enum logic [0:0] {
      ST_INIT,
      ST_RUN
   } state_e;

   localparam state_e RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

   state_e                state_q,     state_d;
   logic [ADDR_WIDTH-1:0] clr_addr_q,  clr_addr_d;
   logic                  init_done_q, init_done_d;

   logic                  ready;
   logic                  wr_in_range, rd_in_range;
   logic                  wr_fire, wr_drop, rd_fire, collide;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [NB-1:0]         mem_wbe;
   logic [DATA_WIDTH-1:0] rd_word;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  stg_valid, stg_err;
   logic [DATA_WIDTH-1:0] stg_data;

   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  rvalid_q,   rvalid_d;
   logic                  rd_err_q,   rd_err_d;
   logic                  wr_err_q,   wr_err_d;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RESET_STATE;
         clr_addr_q  <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_addr_q  <= clr_addr_d;
         init_done_q <= init_done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      case (state_q)
         ST_INIT: begin
            clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
            if (clr_addr_q == LAST_ADDR) begin
               state_d    = ST_RUN;
               clr_addr_d = '0;
            end
         end
         ST_RUN: begin
            clr_addr_d = '0;
         end
         default: begin
            state_d = RESET_STATE;
         end
      endcase
   end

   // Output / datapath control
   always_comb begin
      init_done_d = (state_d == ST_RUN);
      ready       = init_done_q & ~reset;
      wr_in_range = ({1'b0, waddr} < DEPTH_W);
      rd_in_range = ({1'b0, raddr} < DEPTH_W);
      wr_fire     = ready & we & wr_in_range;
      wr_drop     = ready & we & ~wr_in_range;
      rd_fire     = ready & re;
      collide     = wr_fire & (waddr == raddr);

      mem_we    = 1'b0;
      mem_waddr = waddr;
      mem_wdata = data_in;
      mem_wbe   = wbe;
      if (state_q == ST_INIT && !reset) begin
         mem_we    = 1'b1;
         mem_waddr = clr_addr_q;
         mem_wdata = '0;
         mem_wbe   = '1;
      end else if (wr_fire) begin
         mem_we = 1'b1;
      end

      // Write-first merges the enabled incoming bytes over the stored word
      rd_word = '0;
      if (rd_in_range) begin
         rd_word = mem_q[raddr];
         if (COLLISION_MODE != 0 && collide) begin
            for (int unsigned i = 0; i < NB; i++) begin
               if (wbe[i]) begin
                  rd_word[8*i +: 8] = data_in[8*i +: 8];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (mem_wbe[i]) begin
               mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
         end
      end
   end

   // Read data is sampled at the request edge in both latencies so the
   // collision policy is identical; the extra stage only delays delivery.
   if (RD_LATENCY == 2) begin : g_lat2
      logic                  pipe_valid_q, pipe_err_q;
      logic [DATA_WIDTH-1:0] pipe_data_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            pipe_valid_q <= 1'b0;
            pipe_err_q   <= 1'b0;
            pipe_data_q  <= '0;
         end else begin
            pipe_valid_q <= rd_fire;
            pipe_err_q   <= rd_fire & ~rd_in_range;
            pipe_data_q  <= rd_word;
         end
      end

      assign stg_valid = pipe_valid_q;
      assign stg_err   = pipe_err_q;
      assign stg_data  = pipe_data_q;
   end else begin : g_lat1
      assign stg_valid = rd_fire;
      assign stg_err   = rd_fire & ~rd_in_range;
      assign stg_data  = rd_word;
   end

   always_comb begin
      rvalid_d   = stg_valid;
      rd_err_d   = stg_valid & stg_err;
      data_out_d = stg_valid ? stg_data : data_out_q;
      wr_err_d   = wr_drop;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_out_q <= '0;
         rvalid_q   <= 1'b0;
         rd_err_q   <= 1'b0;
         wr_err_q   <= 1'b0;
      end else begin
         data_out_q <= data_out_d;
         rvalid_q   <= rvalid_d;
         rd_err_q   <= rd_err_d;
         wr_err_q   <= wr_err_d;
      end
   end

   assign data_out  = data_out_q;
   assign rvalid    = rvalid_q;
   assign rd_err    = rd_err_q;
   assign wr_err    = wr_err_q;
   assign init_done = init_done_q;

endmodule
